// File: rtl/pwm_duty_sequencer.sv
// Round-robin arbiter that walks the shared PWM duty toward each granted target on period boundaries.
// Define PWM_SEQ_RAMP_EN for one-step ramping every RAMP_PERIODS periods; otherwise the target loads directly.
module pwm_duty_sequencer #(
   parameter int unsigned NREQ         = 2,
   parameter int unsigned PERIOD       = 10,
   parameter int unsigned DUTY_INIT    = 5,
   parameter int unsigned RAMP_PERIODS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [4*NREQ-1:0] tgt,
   input  logic              period_end,
   output logic [3:0]        duty,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   ack,
   output logic              busy
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("NREQ out of range");
   end
   if (PERIOD > 15 || DUTY_INIT > PERIOD) begin : g_bad_period
      $error("PERIOD/DUTY_INIT out of range");
   end
   if (RAMP_PERIODS < 1 || RAMP_PERIODS > 15) begin : g_bad_ramp
      $error("RAMP_PERIODS out of range");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RAMP,
      S_DONE
   } state_t;

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [3:0]      tgt_lat;
`ifdef PWM_SEQ_RAMP_EN
   logic [3:0]      ramp_cnt;
`endif

   logic            found;
   logic [IW-1:0]   sel;
   logic [NREQ-1:0] sel_onehot;
   logic [3:0]      sel_raw;
   logic [3:0]      sel_tgt;

   // Rotating priority: first pass covers indices above the pointer, second pass wraps to 0..pointer.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req[i] && (IW'(i) > ptr)) begin
            found = 1'b1;
            sel   = IW'(i);
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req[i] && (IW'(i) <= ptr)) begin
            found = 1'b1;
            sel   = IW'(i);
         end
      end
      sel_onehot      = '0;
      sel_onehot[sel] = 1'b1;
      sel_raw         = tgt[4*sel +: 4];
      sel_tgt         = (sel_raw > 4'(PERIOD)) ? 4'(PERIOD) : sel_raw;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         duty     <= 4'(DUTY_INIT);
         grant    <= '0;
         ack      <= '0;
         busy     <= 1'b0;
         ptr      <= IW'(NREQ - 1);
         tgt_lat  <= '0;
`ifdef PWM_SEQ_RAMP_EN
         ramp_cnt <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  state    <= S_RAMP;
                  grant    <= sel_onehot;
                  busy     <= 1'b1;
                  ptr      <= sel;
                  tgt_lat  <= sel_tgt;
`ifdef PWM_SEQ_RAMP_EN
                  ramp_cnt <= '0;
`endif
               end
            end
            S_RAMP: begin
               if (duty == tgt_lat) begin
                  state <= S_DONE;
                  ack   <= grant;
               end else if (period_end) begin
`ifdef PWM_SEQ_RAMP_EN
                  if (ramp_cnt == 4'(RAMP_PERIODS - 1)) begin
                     ramp_cnt <= '0;
                     duty     <= (tgt_lat > duty) ? duty + 4'd1 : duty - 4'd1;
                  end else begin
                     ramp_cnt <= ramp_cnt + 4'd1;
                  end
`else
                  duty <= tgt_lat;
`endif
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               grant <= '0;
               ack   <= '0;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Bench for pwm_duty_sequencer: directed scenarios plus random traffic against a behavioural model.
module tb_pwm_duty_sequencer;

   localparam int NREQ      = 3;
   localparam int PERIOD    = 10;
   localparam int DUTY_INIT = 5;
   localparam int RP        = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [4*NREQ-1:0] tgt = '0;
   logic              period_end = 1'b0;
   logic [3:0]        duty;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   ack;
   logic              busy;

   int errors = 0;
   int checks = 0;
   bit pe_rand = 1'b0;
   int pc = 0;

   // behavioural model: served index (-1 when none), done flag, strobes counted toward next step
   int m_duty = DUTY_INIT;
   int m_srv  = -1;
   int m_ptr  = NREQ - 1;
   int m_tgt  = 0;
   int m_cnt  = 0;
   bit m_done = 1'b0;
   bit pe_sampled = 1'b0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   pwm_duty_sequencer #(
      .NREQ(NREQ),
      .PERIOD(PERIOD),
      .DUTY_INIT(DUTY_INIT),
      .RAMP_PERIODS(RP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .tgt(tgt),
      .period_end(period_end),
      .duty(duty),
      .grant(grant),
      .ack(ack),
      .busy(busy)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_step();
      int j;
      int t;
      pe_sampled = period_end;
      started    = 1'b1;
      if (rst) begin
         m_duty = DUTY_INIT;
         m_srv  = -1;
         m_ptr  = NREQ - 1;
         m_cnt  = 0;
         m_done = 1'b0;
      end else if (m_done) begin
         m_done = 1'b0;
         m_srv  = -1;
      end else if (m_srv < 0) begin
         if (req != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
               j = (m_ptr + k) % NREQ;
               if (m_srv < 0 && req[j]) m_srv = j;
            end
            m_ptr = m_srv;
            t     = int'(tgt[4*m_srv +: 4]);
            m_tgt = (t > PERIOD) ? PERIOD : t;
            m_cnt = 0;
         end
      end else if (m_duty == m_tgt) begin
         m_done = 1'b1;
      end else if (period_end) begin
`ifdef PWM_SEQ_RAMP_EN
         m_cnt++;
         if (m_cnt == RP) begin
            m_duty = m_duty + ((m_tgt > m_duty) ? 1 : -1);
            m_cnt  = 0;
         end
`else
         m_duty = m_tgt;
`endif
      end
   endfunction

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // compare process: every output, every cycle after the first edge
   initial forever begin
      @(negedge clk);
      if (started) begin
         chk("duty", int'(duty), m_duty);
         chk("grant", int'(grant), (m_srv >= 0) ? (1 << m_srv) : 0);
         chk("ack", int'(ack), m_done ? (1 << m_srv) : 0);
         chk("busy", int'(busy), (m_srv >= 0) ? 1 : 0);
         chk("duty_range", (int'(duty) <= PERIOD) ? 1 : 0, 1);
      end
   end

   initial forever begin
      @(negedge clk);
      if (pe_rand) begin
         period_end = ($urandom_range(3) == 0);
      end else begin
         pc = (pc + 1) % PERIOD;
         period_end = (pc == PERIOD - 1);
      end
   end

   task automatic wait_ack(input int idx, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack[idx] && n < budget);
      checks++;
      if (!ack[idx]) begin
         errors++;
         $display("FAIL ack_timeout[%0d]: got none expected ack within %0d cycles", idx, budget);
      end
   endtask

   task automatic wait_grant(input int budget, output int g);
      int n;
      n = 0;
      g = -1;
      do begin
         @(negedge clk);
         n++;
      end while (grant == '0 && n < budget);
      for (int i = 0; i < NREQ; i++) if (grant[i] && g < 0) g = i;
      checks++;
      if (grant == '0) begin
         errors++;
         $display("FAIL grant_timeout: got none expected grant within %0d cycles", budget);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n;
      int g;
      // reset with every requester active
      rst = 1'b1;
      req = '1;
      tgt = {4'd5, 4'd5, 4'd5};
      repeat (2) @(negedge clk);
      chk("rst_duty", int'(duty), 5);
      chk("rst_grant", int'(grant), 0);
      chk("rst_ack", int'(ack), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("first_grant", int'(grant), 1);
      do_reset();

      // single ramp 5 -> 8
      tgt[3:0] = 4'd8;
      req[0]   = 1'b1;
      wait_ack(0, 400, n);
      req[0] = 1'b0;
      chk("ramp_duty", int'(duty), 8);
      chk("ramp_model", m_duty, 8);

      // contention from reset: 0,1,0,1
      do_reset();
      tgt[3:0] = 4'd2;
      tgt[7:4] = 4'd9;
      req      = 3'b011;
      for (int s = 0; s < 4; s++) begin
         wait_grant(400, g);
         chk("rr_order", g, s % 2);
         chk("rr_onehot", $countones(grant), 1);
         if (g >= 0) wait_ack(g, 400, n);
      end
      req = '0;
      @(negedge clk);

      // clamp, then a request already at its target
      tgt[7:4] = 4'd15;
      req[1]   = 1'b1;
      wait_ack(1, 400, n);
      req[1] = 1'b0;
      chk("clamp_duty", int'(duty), 10);
      @(negedge clk);
      tgt[3:0] = 4'd10;
      req[0]   = 1'b1;
      wait_ack(0, 10, n);
      req[0] = 1'b0;
      chk("trivial_latency", n, 2);
      chk("trivial_duty", int'(duty), 10);
      @(negedge clk);

      // reset in the middle of a ramp 5 -> 9
      do_reset();
      tgt[3:0] = 4'd9;
      req[0]   = 1'b1;
      n = 0;
      while (duty < 4'd7 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("midramp_reached", (duty >= 4'd7) ? 1 : 0, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_duty", int'(duty), 5);
      chk("midrst_grant", int'(grant), 0);
      chk("midrst_ack", int'(ack), 0);
      rst = 1'b0;
      req = '0;
      @(negedge clk);
      chk("midrst_idle", int'(busy), 0);

      // first update lands on the cycle after a period_end strobe
      do_reset();
      tgt[7:4] = 4'd2;
      req[1]   = 1'b1;
      n = 0;
      while (duty == 4'd5 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("step_on_strobe", int'(pe_sampled), 1);
`ifdef PWM_SEQ_RAMP_EN
      chk("first_step", int'(duty), 4);
      @(negedge clk);
      chk("no_early_ack", int'(ack), 0);
`else
      chk("direct_load", int'(duty), 2);
      @(negedge clk);
      chk("ack_after_load", int'(ack), 2);
`endif
      wait_ack(1, 400, n);
      req[1] = 1'b0;
      @(negedge clk);

      // random traffic with fast random strobes, mid-service drops and target churn
      pe_rand = 1'b1;
      repeat (3000) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
               req[i] = 1'b0;
            end else if (!req[i]) begin
               if ($urandom_range(7) == 0) begin
                  req[i] = 1'b1;
                  tgt[4*i +: 4] = 4'($urandom_range(15));
               end
            end else if ($urandom_range(99) == 0) begin
               req[i] = 1'b0;
            end
            if ($urandom_range(15) == 0) tgt[4*i +: 4] = 4'($urandom_range(15));
         end
         rst = ($urandom_range(299) == 0);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pwm_duty_sequencer.md
# pwm_duty_sequencer

- Arbitrates duty-cycle change requests from up to eight requesters (debounced buttons, host registers, thermal limiter) and sequences the shared PWM generator's duty register toward each granted target.
- Changes are applied one step at a time, only on PWM period boundaries, so the output never glitches mid-period.
- The block sits between the requesters and the PWM compare stage, and takes the period-end strobe from the PWM counter.

## Interface
Parameters:
- NREQ, 2: number of requesters, 2..8.
- PERIOD, 10: PWM counts per period; the maximum legal duty; at most 15.
- DUTY_INIT, 5: duty value after reset.
- RAMP_PERIODS, 1: PWM periods per one-step duty change, 1..15.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  level request per requester; held until its ack.
- tgt  input  4*NREQ  packed target duties; requester i uses bits [4i+3:4i].
- period_end  input  1  one-cycle strobe from the PWM counter on its last count of each period.
- duty  output  4  duty value driven to the PWM compare.
- grant  output  NREQ  one-hot; the requester currently in service.
- ack  output  NREQ  one-cycle completion pulse to the served requester.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- Reset values:
  - duty=DUTY_INIT; grant=0; ack=0; busy=0; state=IDLE; ramp counter=0.
  - Round-robin pointer=NREQ-1, so requester 0 has first priority.
- State IDLE:
  - If any req bit is high, select the first high bit searching upward from pointer+1, modulo NREQ.
  - Latch that requester's target as min(tgt, PERIOD), set the pointer to it, clear the ramp counter and go to RAMP.
  - With no request, stay in IDLE; period_end is ignored.
- State RAMP:
  - grant is one-hot for the served requester; busy=1.
  - If duty==latched target, go to DONE.
  - Otherwise, on each period_end, increment the ramp counter.
  - When period_end arrives with the counter at RAMP_PERIODS-1: duty moves one step toward the target (+1 or -1), and the counter clears.
- State DONE: ack for the served requester is high for this cycle only; grant is still asserted. Next state is IDLE.
- The latched target is unaffected by later tgt or req changes. A req dropped mid-service does not abort the service; ack is still issued.
- A req still high in IDLE after its ack is treated as a new request. Round-robin therefore alternates between continuously requesting masters.
- Duty never leaves 0..PERIOD. A target of 0 or PERIOD ramps to exactly that value, with no wrap-around.
- rst asserted in any state: every output returns to its reset value at the next edge. The in-flight request is abandoned and no ack is issued.

## Timing
- req sampled high in IDLE at edge N: grant and busy are high from cycle N+1.
- Target already equal to duty: DONE at N+2, ack high during cycle N+2, IDLE and grant=0 at N+3.
- Duty update:
  - Registered on the edge where period_end is sampled, so the new duty is valid on the first cycle of the next PWM period.
  - Equality is detected the cycle after the update, and ack follows one cycle later.
- Ramp from d0 to t spans |t-d0|*RAMP_PERIODS period_end strobes.
- Back-to-back service: the next grant asserts at the earliest 2 cycles after the previous ack (DONE→IDLE→RAMP).

## Configuration
- PWM_SEQ_RAMP_EN defined: stepwise ramping as described above.
- PWM_SEQ_RAMP_EN undefined:
  - In RAMP, duty loads the latched target directly on the first period_end; RAMP_PERIODS is ignored and the ramp counter is removed.
  - Arbitration, clamping, ack timing after the update, and reset behaviour are unchanged.

## Test plan
- Reset: hold rst 2 cycles with req=all ones → duty=5, grant=0, ack=0, busy=0. First grant after release goes to requester 0.
- Single ramp:
  - Stimulus: req[0]=1, tgt0=8, RAMP_PERIODS=1, period_end every 10 cycles.
  - Response: duty 6, 7, 8 at the first cycle after three successive strobes; ack[0] pulses once, 2 cycles after duty=8.
- Contention: req[0]=req[1]=1 held continuously, tgt0=2, tgt1=9 → grant order 0, 1, 0, 1. Each ack is a single cycle, and grants never overlap.
- Clamp and trivial request:
  - tgt1=15 with PERIOD=10 → duty settles at 10, never 11.
  - Then tgt0=10 → ack[0] 2 cycles after req, with no duty change.
- Reset mid-ramp: duty at 7 ramping to 9, assert rst for 1 cycle → duty=5, grant=0, no ack; state IDLE next cycle.
- Macro off: duty=5, req[1] with tgt1=2 → duty=2 on the cycle after the first period_end; ack[1] 2 cycles later.
